// File: rtl/data_mem_responder.sv
// Memory-stage data responder: accepts one load/store at a time and answers it
// from a word-organised RAM after a fixed latency with a one-cycle response pulse.
module data_mem_responder #(
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [15:0]       addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   req_t                req_q, req_nxt;
   logic                accept_c;
   logic                commit_c;
   logic                err_c;
   logic [ADDR_BITS-1:0] idx_c;
   logic [DATA_W-1:0]   rdata_c;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Next-state logic; the commit always acts on req_nxt so a LATENCY=1 accept
   // commits the incoming request on the very edge that accepts it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_nxt   = req_q;
      accept_c  = req_valid & req_ready;
      case (state)
         IDLE, RESP: begin
            state_nxt = IDLE;
            if (accept_c) begin
               req_nxt.write = req_write;
               req_nxt.addr  = req_addr;
               req_nxt.wdata = req_wdata;
               cnt_nxt       = CNT_W'(LATENCY - 1);
               state_nxt     = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         default: state_nxt = IDLE;
      endcase

      commit_c = (state_nxt == RESP);
      err_c    = req_nxt.addr[0] | ((req_nxt.addr >> (ADDR_BITS + 1)) != '0);
      idx_c    = req_nxt.addr[ADDR_BITS:1];
      rdata_c  = mem[idx_c];
   end

   // State and registered outputs; data outputs are zero outside the response cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         req_q      <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         req_q      <= req_nxt;
         req_ready  <= (state_nxt != WAIT);
         resp_valid <= commit_c;
         resp_err   <= commit_c & err_c;
         resp_rdata <= (commit_c & ~err_c & ~req_nxt.write) ? rdata_c : '0;
      end
   end

   // RAM is not reset; a store lands on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (commit_c && req_nxt.write && !err_c) mem[idx_c] <= req_nxt.wdata;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, multi-cycle corner
// sequences and a randomized phase checked against a cycle-level memory model.
module tb_data_mem_responder;

   localparam int unsigned AB  = 10;
   localparam int unsigned LAT = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_err;

   data_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        err;
      logic [15:0] rdata;
   } vec_t;

   typedef struct {
      int          due;
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   int          nvec = 0;
   int          nerr = 0;
   logic [15:0] mdl [int];
   vec_t        tbl [$];
   exp_t        exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Access is illegal when misaligned or beyond the 2**(AB+1)-byte window.
   function automatic logic mdl_err(input logic [15:0] a);
      logic [15:0] t;
      t = a;
      return t[0] || (int'(t) >= (2 << AB));
   endfunction

   task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic err, input logic [15:0] rdata, input string id);
      bit found;
      int k;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (req_ready) found = 1;
      end
      if (!found) begin
         chk({id, "_ready_timeout"}, 0, 1);
         return;
      end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      if (wr && !mdl_err(addr)) mdl[int'(addr) >> 1] = wdata;
      found = 0;
      k = 99;
      for (int i = 1; i <= int'(LAT) + 4 && !found; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            found = 1;
            k = i;
         end
      end
      chk({id, "_latency"}, 32'(k), LAT);
      if (found) begin
         chk({id, "_err"}, 32'(resp_err), 32'(err));
         chk({id, "_rdata"}, 32'(resp_rdata), 32'(rdata));
         @(negedge clk);
         chk({id, "_after"}, {resp_valid, resp_err, resp_rdata}, 0);
      end
   endtask

   initial begin
      bit   found;
      int   k;
      int   cyc;
      logic ready_exp;
      logic [15:0] a;

      rst       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset state and release
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_valid", 32'(resp_valid), 0);
      chk("rst_rdata", 32'(resp_rdata), 0);
      chk("rst_err", 32'(resp_err), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(req_ready), 1);

      tbl.push_back('{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000});
      tbl.push_back('{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF});
      tbl.push_back('{1'b1, 16'h0011, 16'hAAAA, 1'b1, 16'h0000});
      tbl.push_back('{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF});
      tbl.push_back('{1'b0, 16'h0800, 16'h0000, 1'b1, 16'h0000});
      tbl.push_back('{1'b1, 16'h07FE, 16'h7E57, 1'b0, 16'h0000});
      tbl.push_back('{1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h7E57});
      tbl.push_back('{1'b1, 16'h0030, 16'h0000, 1'b0, 16'h0000});
      tbl.push_back('{1'b1, 16'hFFFE, 16'hCAFE, 1'b1, 16'h0000});
      tbl.push_back('{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000});
      tbl.push_back('{1'b1, 16'h0000, 16'h0102, 1'b0, 16'h0000});
      tbl.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0102});
      tbl.push_back('{1'b0, 16'h0801, 16'h0000, 1'b1, 16'h0000});

      foreach (tbl[i])
         do_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata,
                   $sformatf("vec%0d", i));

      // Back-to-back: load presented during the store's response cycle
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 16'h1234;
      @(posedge clk);
      #1;
      req_addr  = 16'h0040;
      req_wdata = 16'hDEAD;
      found = 0;
      k = 99;
      for (int i = 1; i <= int'(LAT) + 4 && !found; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            found = 1;
            k = i;
         end
      end
      chk("b2b_st_latency", 32'(k), LAT);
      chk("b2b_st_ready", 32'(req_ready), 1);
      req_write = 1'b0;
      req_addr  = 16'h0020;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mdl[16'h0020 >> 1] = 16'h1234;
      found = 0;
      k = 99;
      for (int i = 1; i <= int'(LAT) + 4 && !found; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            found = 1;
            k = i;
         end
      end
      chk("b2b_ld_latency", 32'(k), LAT);
      chk("b2b_ld_rdata", 32'(resp_rdata), 32'h1234);
      chk("b2b_ld_err", 32'(resp_err), 0);

      // Reset during WAIT loses the outstanding store
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0030;
      req_wdata = 16'h5555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("wrst_ready", 32'(req_ready), 0);
      @(negedge clk);
      rst = 1'b1;
      found = 0;
      for (int i = 0; i < int'(LAT) + 3; i++) begin
         @(negedge clk);
         if (resp_valid) found = 1;
      end
      chk("wrst_no_resp", 32'(found), 0);
      do_access(1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000, "wrst_ld");

      // Prefill a window for the randomized phase
      for (int i = 0; i < 16; i++) begin
         a = 16'(16'h0100 + 2 * i);
         do_access(1'b1, a, 16'(i * 16'h0111), 1'b0, 16'h0000, $sformatf("fill%0d", i));
      end

      // Randomized traffic against the model; expected response due LAT negedges after accept
      cyc = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            chk("rnd_valid", 32'(resp_valid), 1);
            chk("rnd_err", 32'(resp_err), 32'(exp_q[0].err));
            chk("rnd_rdata", 32'(resp_rdata), 32'(exp_q[0].rdata));
            void'(exp_q.pop_front());
            ready_exp = 1'b1;
         end else begin
            chk("rnd_idle", {resp_valid, resp_err, resp_rdata}, 0);
            ready_exp = (exp_q.size() == 0);
         end
         chk("rnd_ready", 32'(req_ready), 32'(ready_exp));

         req_valid = (c < 790) && ($urandom_range(0, 9) < 7);
         req_write = 1'($urandom);
         req_wdata = 16'($urandom);
         case ($urandom_range(0, 9))
            0:       req_addr = 16'(16'h0101 + 2 * $urandom_range(0, 15));
            1:       req_addr = 16'($urandom_range(16'h0800, 16'hFFFF));
            2:       req_addr = 16'h07FE;
            default: req_addr = 16'(16'h0100 + 2 * $urandom_range(0, 15));
         endcase
         if (req_valid && req_ready) begin
            exp_t e;
            e.due   = cyc + int'(LAT);
            e.err   = mdl_err(req_addr);
            e.rdata = (!e.err && !req_write) ? mdl[int'(req_addr) >> 1] : 16'h0000;
            if (req_write && !e.err) mdl[int'(req_addr) >> 1] = req_wdata;
            exp_q.push_back(e);
         end
      end
      req_valid = 1'b0;
      chk("rnd_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
